arbiter_rr_n: RTL and testbench
===============================

Name: arbiter_rr_n

Overview:
- Parametrised N-requester arbiter; successor to the two-requester arbiter.
- Grants a single shared resource (bus/port) to exactly one requester at a time.
- Runtime-selectable policy: round-robin or fixed priority.
- Per-grant quantum counter bounds how long one requester holds the resource under contention.
- Registered one-hot grant plus encoded owner ID; sits between request sources and the shared-resource mux.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- QUANTUM, 8, maximum consecutive grant cycles for one owner while another request is pending; legal range 1..256.
- IDW, $clog2(N), width of grant_id; derived, not overridden.
- CW, QUANTUM>1 ? $clog2(QUANTUM) : 1, quantum counter width; derived.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i is high while requester i wants the resource.
- mode_fixed  input  1  0 = round-robin, 1 = fixed priority (index 0 highest).
- grant  output  N  one-hot registered grant; all-zero when idle.
- grant_valid  output  1  equals |grant.
- grant_id  output  IDW  index of current owner; holds its last value when idle.
- quantum_hit  output  1  one-cycle pulse: owner was pre-empted by quantum expiry.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - grant=0, grant_valid=0, grant_id=0, quantum_hit=0.
  - Counter = 0; RR pointer = N-1, so requester 0 wins the first RR decision.
- Latency: all outputs are registered. A request sampled at edge k is granted at the earliest from edge k onward (visible in cycle k+1). There is no combinational req->grant path.
- States:
  - IDLE: grant_valid=0.
  - OWNED: grant_valid=1, owner=grant_id.
- IDLE:
  - req==0 -> stay IDLE.
  - Any req bit set -> pick a winner, go OWNED, counter=0.
- OWNED, evaluated each edge, in priority order:
  1. req[owner]==0 -> release. If other requests exist, pick the next owner in the same edge (no dead cycle) with counter=0; otherwise go IDLE.
  2. req[owner]==1, another request pending, counter==QUANTUM-1 -> pre-empt. Pick a winner excluding the owner, counter=0, pulse quantum_hit for one cycle.
  3. Otherwise -> keep the owner. Counter increments, saturating at QUANTUM-1. With no contention the owner may hold indefinitely.
- Winner selection:
  - Round-robin: first set req bit scanning from pointer+1 upward, wrapping N-1 -> 0. The pointer updates to the winner on every new grant.
  - Fixed priority: lowest set index, excluding the pre-empted owner on rule 2. The pointer still updates to the winner.
- QUANTUM=1: under continuous contention the grant rotates every cycle; quantum_hit is high every cycle.
- mode_fixed is sampled only at decision points. A change while OWNED does not disturb the current owner.
- Simultaneous owner release and new request at the same index: release wins. That index can be re-granted at the next decision only if it is the sole requester (RR) or highest priority (fixed).
- Reset asserted mid-grant: grant clears immediately, asynchronously.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id == index of the set grant bit whenever grant_valid.
  - The counter never exceeds QUANTUM-1.
- Fairness (RR): with all N requesting continuously, each requester is granted exactly QUANTUM cycles in every N*QUANTUM window.

Decomposition:
- Package arb_pkg:
  - arb_mode_e {ARB_RR=1'b0, ARB_FIXED=1'b1}.
  - arb_state_e {ARB_IDLE, ARB_OWNED}.
  - Function onehot_to_idx for assertion/bench use.
- Sub-module arb_rr_pick, purely combinational:
  - Inputs: req, pointer, mode, exclude mask.
  - Outputs: winner one-hot, winner index, any.
  - Implementation: masked priority encoder using the double-vector technique for wrap-around.
- Top level holds the state register, owner, pointer, counter and the output registers.

Test Plan:
- Reset, then req=4'b0001 held → grant=0001 from cycle 1, grant_id=0, never pre-empted, quantum_hit never pulses.
- N=4, Q=8, RR, req=4'b1111 continuous → grant sequence 0001×8, 0010×8, 0100×8, 1000×8, repeating; quantum_hit pulses at each switch.
- Owner 2 drops req while req=4'b1001 → next grant 1000 on the following edge, no idle cycle; counter restarts at 0.
- Fixed mode, req=4'b0110, Q=2 → 0010×2, 0100×2, 0010×2, …; then drop req[1] → 0100 held indefinitely.
- Q=1, RR, req=4'b0011 → grant alternates 01/10 every cycle; quantum_hit stays high.
- Assert reset mid-grant (asynchronous, between edges) → grant=0 immediately; after release with req=4'b1111 → first grant is 0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-requester arbiter.
// Encodings for the arbitration policy and the ownership state.
package arb_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   // Index of the set bit in a one-hot vector; zero when no bit is set.
   function automatic int unsigned onehot_to_idx(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker: round-robin from pointer+1 with wrap, or
// lowest-index fixed priority, both honouring an exclusion mask.
module arb_rr_pick
   import arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] pointer,
   input  arb_mode_e      mode,
   input  logic [N-1:0]   excl,
   output logic [N-1:0]   win_oh,
   output logic [IDW-1:0] win_idx,
   output logic           any
);

   logic [N-1:0]   elig;
   logic [N-1:0]   hi_mask;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] dbl_first;
   logic [N-1:0]   rr_oh;
   logic [N-1:0]   fp_oh;

   // Lower half holds only bits above the pointer, so the lowest set bit of
   // the doubled vector is the next requester in circular order.
   always_comb begin
      elig = req & ~excl;
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = (32'(i) > 32'(pointer));
      end
      dbl       = {elig, elig & hi_mask};
      dbl_first = dbl & ((~dbl) + {{(2*N-1){1'b0}}, 1'b1});
      rr_oh     = dbl_first[N-1:0] | dbl_first[2*N-1:N];
      fp_oh     = elig & ((~elig) + {{(N-1){1'b0}}, 1'b1});
      win_oh    = (mode == ARB_FIXED) ? fp_oh : rr_oh;
      win_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (win_oh[i]) win_idx = IDW'(i);
      end
      any = |elig;
   end

endmodule

// File: rtl/arbiter_rr_n.sv
// N-requester arbiter with runtime round-robin / fixed-priority policy and a
// per-grant quantum that bounds ownership under contention.
module arbiter_rr_n
   import arb_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int QUANTUM = 8,
   localparam int IDW     = $clog2(N),
   localparam int CW      = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic           mode_fixed,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic           quantum_hit
);

   localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [IDW-1:0] id_q, id_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           qhit_q, qhit_d;

   arb_mode_e      mode;
   logic [N-1:0]   excl;
   logic [N-1:0]   pick_oh;
   logic [IDW-1:0] pick_idx;
   logic           pick_any;
   logic           owner_req;
   logic           others;
   logic           take;

   assign mode = arb_mode_e'(mode_fixed);
   assign excl = (state_q == ARB_OWNED) ? grant_q : '0;

   arb_rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req     (req),
      .pointer (ptr_q),
      .mode    (mode),
      .excl    (excl),
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // Release beats pre-emption, which beats keeping the owner.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      qhit_d    = 1'b0;
      take      = 1'b0;
      owner_req = |(req & grant_q);
      others    = |(req & ~grant_q);
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) take = 1'b1;
         end
         ARB_OWNED: begin
            if (!owner_req) begin
               if (pick_any) begin
                  take = 1'b1;
               end else begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end
            end else if (others && (cnt_q == CNT_MAX)) begin
               take   = 1'b1;
               qhit_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      if (take) begin
         state_d = ARB_OWNED;
         grant_d = pick_oh;
         id_d    = pick_idx;
         ptr_d   = pick_idx;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         id_q    <= '0;
         ptr_q   <= IDW'(N - 1);
         cnt_q   <= '0;
         qhit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         qhit_q  <= qhit_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = id_q;
   assign quantum_hit = qhit_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Directed bench for arbiter_rr_n: three instances (QUANTUM 8, 2, 1) share
// the same stimulus; each scenario checks the instance it targets.
module tb_arbiter_rr_n;
   import arb_pkg::*;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       mode_fixed;

   logic [3:0] g8, g2, g1;
   logic       v8, v2, v1;
   logic [1:0] id8, id2, id1;
   logic       qh8, qh2, qh1;

   int vectors;
   int miscompares;

   arbiter_rr_n #(.N(4), .QUANTUM(8)) dut8 (
      .clk(clk), .reset(reset), .req(req), .mode_fixed(mode_fixed),
      .grant(g8), .grant_valid(v8), .grant_id(id8), .quantum_hit(qh8)
   );
   arbiter_rr_n #(.N(4), .QUANTUM(2)) dut2 (
      .clk(clk), .reset(reset), .req(req), .mode_fixed(mode_fixed),
      .grant(g2), .grant_valid(v2), .grant_id(id2), .quantum_hit(qh2)
   );
   arbiter_rr_n #(.N(4), .QUANTUM(1)) dut1 (
      .clk(clk), .reset(reset), .req(req), .mode_fixed(mode_fixed),
      .grant(g1), .grant_valid(v1), .grant_id(id1), .quantum_hit(qh1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1ns after the edge for sampling/driving.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] expg;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      req         = 4'b0000;
      mode_fixed  = 1'b0;
      #1 reset = 1'b1;
      #2;
      checkOutput("rst_grant", 32'(g8), 32'h0);
      checkOutput("rst_valid", 32'(v8), 32'h0);
      checkOutput("rst_id", 32'(id8), 32'h0);
      checkOutput("rst_qhit", 32'(qh8), 32'h0);

      // Single requester holds forever.
      reset = 1'b0;
      req   = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         applyStimulus();
         checkOutput("solo_grant", 32'(g8), 32'h1);
         checkOutput("solo_qhit", 32'(qh8), 32'h0);
      end
      checkOutput("solo_id", 32'(id8), 32'h0);
      checkOutput("solo_valid", 32'(v8), 32'h1);

      // Full contention, round-robin, Q=8.
      pulseReset();
      req = 4'b1111;
      for (int c = 0; c < 64; c++) begin
         applyStimulus();
         expg = 4'b0001 << ((c / 8) % 4);
         checkOutput("rr_grant", 32'(g8), 32'(expg));
         checkOutput("rr_qhit", 32'(qh8), (c > 0 && (c % 8) == 0) ? 32'h1 : 32'h0);
         checkOutput("rr_id", 32'(id8), onehot_to_idx(32'(expg)));
      end

      // Owner 2 releases while 0 and 3 wait: handoff to 3 with no dead cycle.
      pulseReset();
      req = 4'b0100;
      applyStimulus();
      checkOutput("rel_own2", 32'(g8), 32'h4);
      checkOutput("rel_id2", 32'(id8), 32'h2);
      req = 4'b1001;
      applyStimulus();
      checkOutput("rel_next", 32'(g8), 32'h8);
      checkOutput("rel_qhit", 32'(qh8), 32'h0);
      for (int c = 0; c < 7; c++) begin
         applyStimulus();
         checkOutput("rel_hold", 32'(g8), 32'h8);
      end
      applyStimulus();
      checkOutput("rel_wrap", 32'(g8), 32'h1);
      checkOutput("rel_wrap_qhit", 32'(qh8), 32'h1);

      // Fixed priority, Q=2.
      pulseReset();
      mode_fixed = 1'b1;
      req        = 4'b0110;
      for (int c = 0; c < 12; c++) begin
         applyStimulus();
         checkOutput("fix_grant", 32'(g2), ((c / 2) % 2 == 0) ? 32'h2 : 32'h4);
         checkOutput("fix_qhit", 32'(qh2), (c > 0 && (c % 2) == 0) ? 32'h1 : 32'h0);
      end
      req = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         applyStimulus();
         checkOutput("fix_hold", 32'(g2), 32'h4);
         checkOutput("fix_hold_qhit", 32'(qh2), 32'h0);
      end

      // Q=1 round-robin alternates every cycle.
      pulseReset();
      mode_fixed = 1'b0;
      req        = 4'b0011;
      for (int c = 0; c < 10; c++) begin
         applyStimulus();
         checkOutput("q1_grant", 32'(g1), (c % 2 == 0) ? 32'h1 : 32'h2);
         checkOutput("q1_qhit", 32'(qh1), (c > 0) ? 32'h1 : 32'h0);
      end

      // Asynchronous reset between edges while a grant is held.
      pulseReset();
      req = 4'b1111;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("async_pre", 32'(g8), 32'h1);
      #3 reset = 1'b1;
      #1;
      checkOutput("async_grant", 32'(g8), 32'h0);
      checkOutput("async_valid", 32'(v8), 32'h0);
      checkOutput("async_id", 32'(id8), 32'h0);
      #1 reset = 1'b0;
      applyStimulus();
      checkOutput("async_first", 32'(g8), 32'h1);
      checkOutput("async_first_id", 32'(id8), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
